// File: rtl/jellyvl_synctimer_pkg.sv
// Shared types for the synctimer correction sequencer: FSM state encoding and
// default-width phase-error types.
package jellyvl_synctimer_pkg;

    localparam int STATE_WIDTH = 3;
    localparam int CALC_WIDTH_DEFAULT = 32;

    typedef enum logic [STATE_WIDTH-1:0] {
        SYNC_IDLE     = 3'd0,
        SYNC_ACQUIRE  = 3'd1,
        SYNC_LOCKED   = 3'd2,
        SYNC_HOLDOVER = 3'd3
    } t_sync_state;

    typedef logic signed [CALC_WIDTH_DEFAULT-1:0] t_calc_err;
    typedef logic        [CALC_WIDTH_DEFAULT-1:0] t_calc_mag;

endpackage

// File: rtl/jellyvl_synctimer_correct_ctl_if.sv
// Sample-in / correction-out stream bundle of the synctimer correction sequencer.
interface jellyvl_synctimer_correct_ctl_if #(
    parameter int TIMER_WIDTH = 64
);
    // No ready on either side: s_valid is a one-cycle strobe (at most one sample
    // per cycle) and m_correct_valid is a one-cycle pulse that qualifies
    // m_correct_time and m_correct_override; consumers must accept every pulse.
    logic [TIMER_WIDTH-1:0] s_time;
    logic                   s_valid;
    logic                   m_correct_override;
    logic [TIMER_WIDTH-1:0] m_correct_time;
    logic                   m_correct_valid;

    modport master (
        output s_time, s_valid,
        input  m_correct_override, m_correct_time, m_correct_valid
    );

    modport slave (
        input  s_time, s_valid,
        output m_correct_override, m_correct_time, m_correct_valid
    );
endinterface

// File: rtl/jellyvl_synctimer_watchdog.sv
// Sample-loss watchdog: counts cycles since the last clear and raises a
// combinational expire flag once the count reaches param_timeout (0 disables).
module jellyvl_synctimer_watchdog #(
    parameter int TIMEOUT_WIDTH = 32
) (
    input  logic                     reset,
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     run,
    input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
    output logic                     expire
);
    logic [TIMEOUT_WIDTH-1:0] cnt;
    logic [TIMEOUT_WIDTH-1:0] cnt_inc;
    logic                     disabled;

    assign disabled = (param_timeout == '0);
    assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;
    assign expire   = run && !clear && !disabled && (cnt_inc >= param_timeout);

    always_ff @(posedge clk) begin
        if (reset || clear || disabled) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_inc;
        end
    end
endmodule

// File: rtl/jellyvl_synctimer_correct_ctl.sv
// Synctimer correction sequencer: per-sample override/track decision, lock FSM,
// sample-loss watchdog. Optional statistics ports: JELLYVL_SYNCTIMER_CORRECT_CTL_STATS_EN.
module jellyvl_synctimer_correct_ctl
    import jellyvl_synctimer_pkg::*;
#(
    parameter int TIMER_WIDTH   = 64,
    parameter int CALC_WIDTH    = 32,
    parameter int COUNT_WIDTH   = 16,
    parameter int TIMEOUT_WIDTH = 32,
    parameter int LATENCY       = 2
) (
    input  logic                     reset,
    input  logic                     clk,
    input  logic                     enable,
    input  logic [CALC_WIDTH-1:0]    param_threshold,
    input  logic [COUNT_WIDTH-1:0]   param_lock_count,
    input  logic [COUNT_WIDTH-1:0]   param_unlock_count,
    input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
    input  logic [TIMER_WIDTH-1:0]   local_time,
    jellyvl_synctimer_correct_ctl_if.slave bus,
    output logic [STATE_WIDTH-1:0]   status_state,
    output logic                     status_locked,
    output logic                     status_timeout
`ifdef JELLYVL_SYNCTIMER_CORRECT_CTL_STATS_EN
    ,
    output logic [31:0]              stat_override_count,
    output logic [31:0]              stat_timeout_count,
    output logic [CALC_WIDTH-1:0]    stat_max_error
`endif
);
    t_sync_state            state, state_next;
    logic [COUNT_WIDTH-1:0] acq_cnt, acq_next, acq_inc;
    logic [COUNT_WIDTH-1:0] bad_cnt, bad_next, bad_inc;
    logic                   p0_valid;
    logic [CALC_WIDTH-1:0]  p0_mag;
    logic [TIMER_WIDTH-1:0] p0_time;
    logic [CALC_WIDTH-1:0]  diff, mag;
    logic                   good, dec_override, timeout_next;
    logic                   wd_run, wd_clear, wd_expire;
    logic                   unused_local_hi;

    assign unused_local_hi = ^local_time[TIMER_WIDTH-1:CALC_WIDTH];

    // Wrapped phase error; the most-negative value has no positive twin, so saturate.
    always_comb begin
        diff = bus.s_time[CALC_WIDTH-1:0] - local_time[CALC_WIDTH-1:0];
        if (diff == {1'b1, {(CALC_WIDTH-1){1'b0}}}) begin
            mag = {1'b0, {(CALC_WIDTH-1){1'b1}}};
        end else if (diff[CALC_WIDTH-1]) begin
            mag = -diff;
        end else begin
            mag = diff;
        end
    end

    assign good    = (p0_mag <= param_threshold);
    assign acq_inc = (&acq_cnt) ? acq_cnt : acq_cnt + 1'b1;
    assign bad_inc = (&bad_cnt) ? bad_cnt : bad_cnt + 1'b1;

    assign wd_run   = (state == SYNC_ACQUIRE) || (state == SYNC_LOCKED);
    assign wd_clear = bus.s_valid || !wd_run || !enable;

    jellyvl_synctimer_watchdog #(
        .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
    ) u_watchdog (
        .reset        (reset),
        .clk          (clk),
        .clear        (wd_clear),
        .run          (wd_run),
        .param_timeout(param_timeout),
        .expire       (wd_expire)
    );

    // Stage-1 decision; a sample being decided pre-empts a watchdog expiry.
    always_comb begin
        state_next   = state;
        acq_next     = acq_cnt;
        bad_next     = bad_cnt;
        dec_override = 1'b0;
        timeout_next = 1'b0;
        if (p0_valid) begin
            case (state)
                SYNC_ACQUIRE: begin
                    if (good) begin
                        acq_next = acq_inc;
                        if (acq_inc >= param_lock_count) begin
                            state_next = SYNC_LOCKED;
                            bad_next   = '0;
                        end
                    end else begin
                        dec_override = 1'b1;
                        acq_next     = '0;
                    end
                end
                SYNC_LOCKED: begin
                    if (good) begin
                        bad_next = '0;
                    end else if (bad_inc >= param_unlock_count) begin
                        dec_override = 1'b1;
                        state_next   = SYNC_ACQUIRE;
                        acq_next     = '0;
                    end else begin
                        bad_next = bad_inc;
                    end
                end
                default: begin
                    dec_override = 1'b1;
                    state_next   = SYNC_ACQUIRE;
                    acq_next     = '0;
                end
            endcase
        end else if (wd_expire) begin
            state_next   = SYNC_HOLDOVER;
            timeout_next = 1'b1;
        end
    end

    // Control state: disabling behaves like a reset for the sequencer.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state               <= SYNC_IDLE;
            acq_cnt             <= '0;
            bad_cnt             <= '0;
            p0_valid            <= 1'b0;
            bus.m_correct_valid <= 1'b0;
            status_timeout      <= 1'b0;
        end else begin
            state               <= state_next;
            acq_cnt             <= acq_next;
            bad_cnt             <= bad_next;
            p0_valid            <= bus.s_valid;
            bus.m_correct_valid <= p0_valid;
            status_timeout      <= timeout_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p0_mag                 <= '0;
            p0_time                <= '0;
            bus.m_correct_override <= 1'b0;
            bus.m_correct_time     <= '0;
        end else begin
            if (bus.s_valid) begin
                p0_mag  <= mag;
                p0_time <= bus.s_time + TIMER_WIDTH'(LATENCY);
            end
            if (p0_valid) begin
                bus.m_correct_override <= dec_override;
                bus.m_correct_time     <= p0_time;
            end
        end
    end

    assign status_state  = state;
    assign status_locked = (state == SYNC_LOCKED);

`ifdef JELLYVL_SYNCTIMER_CORRECT_CTL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_override_count <= '0;
            stat_timeout_count  <= '0;
            stat_max_error      <= '0;
        end else if (enable) begin
            if (p0_valid && dec_override) begin
                stat_override_count <= stat_override_count + 1'b1;
            end
            if (timeout_next) begin
                stat_timeout_count <= stat_timeout_count + 1'b1;
            end
            if (p0_valid && (state == SYNC_LOCKED) && (p0_mag > stat_max_error)) begin
                stat_max_error <= p0_mag;
            end
        end
    end
`endif
endmodule

// File: tb/tb_jellyvl_synctimer_correct_ctl.sv
// Bench for jellyvl_synctimer_correct_ctl: directed steps plus randomized samples
// scored against a rule-level reference model.
module tb_jellyvl_synctimer_correct_ctl;
    localparam int TW = 64;
    localparam int CW = 32;
    localparam int NW = 16;
    localparam int OW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [CW-1:0] param_threshold;
    logic [NW-1:0] param_lock_count;
    logic [NW-1:0] param_unlock_count;
    logic [OW-1:0] param_timeout;
    logic [TW-1:0] local_time;
    logic [2:0]    status_state;
    logic          status_locked;
    logic          status_timeout;
`ifdef JELLYVL_SYNCTIMER_CORRECT_CTL_STATS_EN
    logic [31:0]   stat_override_count;
    logic [31:0]   stat_timeout_count;
    logic [CW-1:0] stat_max_error;
`endif

    jellyvl_synctimer_correct_ctl_if #(.TIMER_WIDTH(TW)) bus ();

    jellyvl_synctimer_correct_ctl #(
        .TIMER_WIDTH(TW), .CALC_WIDTH(CW), .COUNT_WIDTH(NW), .TIMEOUT_WIDTH(OW), .LATENCY(2)
    ) dut (
        .reset             (reset),
        .clk               (clk),
        .enable            (enable),
        .param_threshold   (param_threshold),
        .param_lock_count  (param_lock_count),
        .param_unlock_count(param_unlock_count),
        .param_timeout     (param_timeout),
        .local_time        (local_time),
        .bus               (bus.slave),
        .status_state      (status_state),
        .status_locked     (status_locked),
        .status_timeout    (status_timeout)
`ifdef JELLYVL_SYNCTIMER_CORRECT_CTL_STATS_EN
        ,
        .stat_override_count(stat_override_count),
        .stat_timeout_count (stat_timeout_count),
        .stat_max_error     (stat_max_error)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    // scoreboard entry: {state after decision[2:0], override, time[63:0]}
    logic [67:0] exp_q[$];
    logic [67:0] mon_e;

    // reference model: state number (0..3) and consecutive good/bad runs
    int ref_state;
    int ref_good_run;
    int ref_bad_run;

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_reset();
        ref_state    = 0;
        ref_good_run = 0;
        ref_bad_run  = 0;
    endtask

    task automatic ref_decide(input logic [63:0] lt, input logic [63:0] st, output logic ovr);
        logic [31:0] d;
        longint      err, mag, thr;
        bit          good;
        d   = st[31:0] - lt[31:0];
        err = longint'($signed(d));
        mag = (err < 0) ? -err : err;
        if (mag > 64'sd2147483647) mag = 64'sd2147483647;
        thr  = param_threshold;
        good = (mag <= thr);
        ovr  = 1'b0;
        if (ref_state == 0 || ref_state == 3) begin
            ovr = 1'b1; ref_state = 1; ref_good_run = 0;
        end else if (ref_state == 1) begin
            if (good) begin
                ref_good_run++;
                if (ref_good_run >= int'(param_lock_count)) begin
                    ref_state = 2; ref_bad_run = 0;
                end
            end else begin
                ovr = 1'b1; ref_good_run = 0;
            end
        end else begin
            if (good) begin
                ref_bad_run = 0;
            end else begin
                ref_bad_run++;
                if (ref_bad_run >= int'(param_unlock_count)) begin
                    ovr = 1'b1; ref_state = 1; ref_good_run = 0;
                end
            end
        end
    endtask

    // driver: one-cycle s_valid strobe; when expect_out is set the model is stepped
    task automatic send_raw(input logic [63:0] lt, input logic [63:0] st, input bit expect_out);
        logic ovr;
        if (expect_out) begin
            ref_decide(lt, st, ovr);
            exp_q.push_back({3'(ref_state), ovr, st + 64'd2});
        end
        local_time  = lt;
        bus.s_time  = st;
        bus.s_valid = 1'b1;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic send(input longint err, input bit expect_out);
        logic [63:0] lt;
        lt = {$urandom, $urandom};
        send_raw(lt, lt + 64'(err), expect_out);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        idle(4);
        check(tag, 68'(exp_q.size()), 68'd0);
    endtask

    // monitor: every correction pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (started && bus.m_correct_valid === 1'b1) begin
            check("exp_q_nonempty", 68'(exp_q.size() != 0), 68'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("corr_time", 68'(bus.m_correct_time), 68'(mon_e[63:0]));
                check("corr_override", 68'(bus.m_correct_override), 68'(mon_e[64]));
                check("corr_state", 68'(status_state), 68'(mon_e[67:65]));
            end
        end
    end

    initial begin
        longint err;
        bit     early;
        reset              = 1'b1;
        enable             = 1'b1;
        param_threshold    = 32'd8;
        param_lock_count   = 16'd3;
        param_unlock_count = 16'd2;
        param_timeout      = '0;
        local_time         = '0;
        bus.s_time         = '0;
        bus.s_valid        = 1'b0;
        ref_reset();
        idle(3);

        // reset state
        check("rst_state", 68'(status_state), 68'd0);
        check("rst_locked", 68'(status_locked), 68'd0);
        check("rst_timeout", 68'(status_timeout), 68'd0);
        check("rst_valid", 68'(bus.m_correct_valid), 68'd0);
        check("rst_override", 68'(bus.m_correct_override), 68'd0);
        check("rst_time", 68'(bus.m_correct_time), 68'd0);
        reset   = 1'b0;
        started = 1'b1;

        // first sample from IDLE: override, exactly two cycles of latency
        send_raw(64'd0, 64'd1000, 1'b1);
        check("lat_cycle1", 68'(bus.m_correct_valid), 68'd0);
        idle(1);
        check("lat_cycle2", 68'(bus.m_correct_valid), 68'd1);
        drain("drain_first");

        // lock after three good samples
        repeat (3) send(5, 1'b1);
        drain("drain_lock");
        check("locked", 68'(status_locked), 68'd1);

        // unlock sequence: bad run broken by a good sample, then two bad
        send(20, 1'b1); send(3, 1'b1); send(20, 1'b1); send(20, 1'b1);
        drain("drain_unlock");
        check("unlock_state", 68'(status_state), 68'd1);
        repeat (3) send(-4, 1'b1);
        drain("drain_relock");
        check("relocked", 68'(status_locked), 68'd1);

        // watchdog: last sample, then 100 silent cycles
        param_timeout = 32'd100;
        send(1, 1'b1);
        early = 1'b0;
        for (int i = 1; i < 100; i++) begin
            idle(1);
            if (status_timeout) early = 1'b1;
        end
        idle(1);
        check("timeout_early", 68'(early), 68'd0);
        check("timeout_pulse", 68'(status_timeout), 68'd1);
        check("timeout_state", 68'(status_state), 68'd3);
        idle(1);
        check("timeout_one_cycle", 68'(status_timeout), 68'd0);
        ref_state = 3;
        send(5, 1'b1);
        drain("drain_holdover");
        param_timeout = '0;

        // magnitude saturation at the negative extreme
        param_threshold = 32'h7FFF_FFFE;
        send(-64'sd2147483648, 1'b1);
        send(-64'sd2147483646, 1'b1);
        send(64'sd2147483647, 1'b1);
        drain("drain_sat");
        param_threshold = 32'd8;

        // sample in flight during reset is dropped
        send(2, 1'b0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        ref_reset();
        drain("drain_reset_flight");
        check("reset_flight_state", 68'(status_state), 68'd0);

        // randomized samples, gaps and parameters
        for (int r = 0; r < 3; r++) begin
            param_threshold    = 32'($urandom_range(4, 40));
            param_lock_count   = 16'($urandom_range(0, 4));
            param_unlock_count = 16'($urandom_range(0, 3));
            for (int n = 0; n < 30; n++) begin
                case ($urandom_range(0, 3))
                    0: err = longint'($urandom_range(0, param_threshold));
                    1: err = longint'(param_threshold) + 1 + longint'($urandom_range(0, 50));
                    2: err = longint'($urandom_range(0, 2 * param_threshold + 2));
                    default: err = $urandom_range(0, 1) ? 64'sd2147483647 : 64'sd2147483648;
                endcase
                if ($urandom_range(0, 1) != 0) err = -err;
                send(err, 1'b1);
                idle($urandom_range(0, 2));
            end
            drain("drain_random");
        end
        param_threshold = 32'd8;

        // enable dropped mid-burst of back-to-back samples
        for (int i = 0; i < 10; i++) begin
            if (i == 5) enable = 1'b0;
            send(1, i < 4);
        end
        check("disable_state", 68'(status_state), 68'd0);
        check("disable_valid", 68'(bus.m_correct_valid), 68'd0);
        ref_reset();
        drain("drain_disable");
        enable = 1'b1;
        send(0, 1'b1);
        drain("drain_reenable");
        check("reenable_state", 68'(status_state), 68'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
